// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared width codes, funct3 constants and FSM states for the data_mem initiator
package lsu_pkg;

  localparam logic [1:0] WIDTH_WORD = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b10;
  localparam logic [1:0] WIDTH_BYTE = 2'b01;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Access size in bytes from funct3[1:0]; the reserved size 11 is rejected by decode.
  function automatic logic [2:0] access_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   access_bytes = 3'd1;
      2'b01:   access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

  // data_mem WidthSrc code for a whole (aligned) access.
  function automatic logic [1:0] width_code(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   width_code = WIDTH_BYTE;
      2'b01:   width_code = WIDTH_HALF;
      default: width_code = WIDTH_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of raw load data by RV32I funct3
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_raw,
  output logic [31:0] o_data
);

  // Pick the extension rule; anything not a sub-word load passes through untouched.
  always_comb begin
    o_data = i_raw;
    case (i_funct3)
      F3_B:    o_data = {{24{i_raw[7]}}, i_raw[7:0]};
      F3_BU:   o_data = {24'd0, i_raw[7:0]};
      F3_H:    o_data = {{16{i_raw[15]}}, i_raw[15:0]};
      F3_HU:   o_data = {16'd0, i_raw[15:0]};
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-outstanding load/store initiator for the data_mem port
module mem_access_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter bit SPLIT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_we,
  output logic [1:0]  mem_width_src,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      r_state;
  state_t      w_next_state;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic        r_split;
  logic [2:0]  r_nbeats;
  logic [1:0]  r_beat;
  logic [31:0] r_asm;

  logic [2:0]  w_size;
  logic        w_f3_ok;
  logic        w_misaligned;
  logic [32:0] w_last;
  logic        w_out_of_range;
  logic        w_err;
  logic        w_last_beat;
  logic [7:0]  w_wbyte;
  logic [31:0] w_ext;

  // Decode the incoming request; the 33-bit end address turns a 32-bit wrap into out-of-range.
  always_comb begin
    w_size = access_bytes(req_funct3);
    if (req_we) begin
      w_f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    end else begin
      w_f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    end
    case (req_funct3[1:0])
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = (req_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
    w_last         = {1'b0, req_addr} + {30'd0, w_size} - 33'd1;
    w_out_of_range = (w_last >= 33'(MEM_BYTES));
    w_err          = !w_f3_ok || (w_misaligned && !SPLIT_EN) || w_out_of_range;
  end

  assign w_last_beat = ({1'b0, r_beat} == (r_nbeats - 3'd1));

  // FSM state register; reset aborts any beat in progress without a response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state: errors skip straight to the response, accesses run nbeats beats.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next_state = w_err ? RESP : ACCESS;
      ACCESS:  if (w_last_beat) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request latch, beat counter and little-endian load assembly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_err    <= 1'b0;
      r_split  <= 1'b0;
      r_nbeats <= 3'd1;
      r_beat   <= 2'd0;
      r_asm    <= 32'd0;
    end else begin
      if (r_state == IDLE && req_valid) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_err;
        r_split  <= w_misaligned;
        r_nbeats <= w_misaligned ? w_size : 3'd1;
        r_beat   <= 2'd0;
        r_asm    <= 32'd0;
      end else if (r_state == ACCESS) begin
        r_beat <= r_beat + 2'd1;
        if (!r_we) begin
          if (r_split) begin
            r_asm[{r_beat, 3'b000} +: 8] <= mem_rdata[7:0];
          end else begin
            r_asm <= mem_rdata;
          end
        end
      end
    end
  end

  assign w_wbyte = r_wdata[{r_beat, 3'b000} +: 8];

  load_extend u_load_extend (
    .i_funct3 (r_funct3),
    .i_raw    (r_asm),
    .o_data   (w_ext)
  );

  // Drive the memory port only during ACCESS so reset or idle leaves it quiet.
  always_comb begin
    req_ready     = (r_state == IDLE);
    resp_valid    = 1'b0;
    resp_err      = 1'b0;
    resp_rdata    = 32'd0;
    mem_we        = 1'b0;
    mem_width_src = WIDTH_WORD;
    mem_addr      = 32'd0;
    mem_wdata     = 32'd0;
    if (r_state == ACCESS) begin
      mem_we = r_we;
      if (r_split) begin
        mem_width_src = WIDTH_BYTE;
        mem_addr      = r_addr + {30'd0, r_beat};
        mem_wdata     = {24'd0, w_wbyte};
      end else begin
        mem_width_src = width_code(r_funct3);
        mem_addr      = r_addr;
        mem_wdata     = r_wdata;
      end
    end else if (r_state == RESP) begin
      resp_valid = 1'b1;
      resp_err   = r_err;
      resp_rdata = (r_err || r_we) ? 32'd0 : w_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        s_req_ready, s_resp_valid, s_resp_err, s_mem_we;
  logic [31:0] s_resp_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [1:0]  s_mem_width_src;
  logic        n_req_ready, n_resp_valid, n_resp_err, n_mem_we;
  logic [31:0] n_resp_rdata, n_mem_addr, n_mem_wdata, n_mem_rdata;
  logic [1:0]  n_mem_width_src;

  logic [7:0] s_mem [0:255];
  logic [7:0] n_mem [0:255];

  int checks = 0;
  int failures = 0;

  mem_access_ctrl #(.MEM_BYTES(256), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(s_req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(s_resp_valid), .resp_err(s_resp_err), .resp_rdata(s_resp_rdata),
    .mem_we(s_mem_we), .mem_width_src(s_mem_width_src), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata)
  );

  mem_access_ctrl #(.MEM_BYTES(256), .SPLIT_EN(1'b0)) dut_nosplit (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(n_req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(n_resp_valid), .resp_err(n_resp_err), .resp_rdata(n_resp_rdata),
    .mem_we(n_mem_we), .mem_width_src(n_mem_width_src), .mem_addr(n_mem_addr),
    .mem_wdata(n_mem_wdata), .mem_rdata(n_mem_rdata)
  );

  // data_mem models: combinational little-endian read, write on rising edge
  always_comb begin
    case (s_mem_width_src)
      2'b01:   s_mem_rdata = {24'd0, s_mem[s_mem_addr[7:0]]};
      2'b10:   s_mem_rdata = {16'd0, s_mem[s_mem_addr[7:0] + 8'd1], s_mem[s_mem_addr[7:0]]};
      default: s_mem_rdata = {s_mem[s_mem_addr[7:0] + 8'd3], s_mem[s_mem_addr[7:0] + 8'd2],
                              s_mem[s_mem_addr[7:0] + 8'd1], s_mem[s_mem_addr[7:0]]};
    endcase
    case (n_mem_width_src)
      2'b01:   n_mem_rdata = {24'd0, n_mem[n_mem_addr[7:0]]};
      2'b10:   n_mem_rdata = {16'd0, n_mem[n_mem_addr[7:0] + 8'd1], n_mem[n_mem_addr[7:0]]};
      default: n_mem_rdata = {n_mem[n_mem_addr[7:0] + 8'd3], n_mem[n_mem_addr[7:0] + 8'd2],
                              n_mem[n_mem_addr[7:0] + 8'd1], n_mem[n_mem_addr[7:0]]};
    endcase
  end

  always @(posedge clk) begin
    if (s_mem_we) begin
      s_mem[s_mem_addr[7:0]] <= s_mem_wdata[7:0];
      if (s_mem_width_src != 2'b01) s_mem[s_mem_addr[7:0] + 8'd1] <= s_mem_wdata[15:8];
      if (s_mem_width_src == 2'b00) begin
        s_mem[s_mem_addr[7:0] + 8'd2] <= s_mem_wdata[23:16];
        s_mem[s_mem_addr[7:0] + 8'd3] <= s_mem_wdata[31:24];
      end
    end
    if (n_mem_we) begin
      n_mem[n_mem_addr[7:0]] <= n_mem_wdata[7:0];
      if (n_mem_width_src != 2'b01) n_mem[n_mem_addr[7:0] + 8'd1] <= n_mem_wdata[15:8];
      if (n_mem_width_src == 2'b00) begin
        n_mem[n_mem_addr[7:0] + 8'd2] <= n_mem_wdata[23:16];
        n_mem[n_mem_addr[7:0] + 8'd3] <= n_mem_wdata[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  int          r_cyc, nb, n_we, n_ready, ns_cyc, ns_we;
  logic        r_err, ns_err;
  logic [31:0] r_rdata;
  logic [31:0] b_addr [0:7];
  logic [31:0] b_wd   [0:7];
  logic [1:0]  b_ws   [0:7];

  // Present one request for one edge, then trace both DUTs until each responds (bounded).
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    r_cyc = 0; nb = 0; n_we = 0; n_ready = 0; ns_cyc = 0; ns_we = 0;
    r_err = 1'b0; ns_err = 1'b0; r_rdata = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (s_mem_we) n_we++;
      if (n_mem_we) ns_we++;
      if (r_cyc == 0) begin
        if (s_req_ready) n_ready++;
        if (s_resp_valid) begin
          r_cyc = c; r_err = s_resp_err; r_rdata = s_resp_rdata;
        end else if (nb < 8) begin
          b_addr[nb] = s_mem_addr; b_wd[nb] = s_mem_wdata; b_ws[nb] = s_mem_width_src;
          nb++;
        end
      end
      if (ns_cyc == 0 && n_resp_valid) begin
        ns_cyc = c; ns_err = n_resp_err;
      end
      if (r_cyc != 0 && ns_cyc != 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  logic [7:0]  exp_b [0:3];
  logic [2:0]  e_f3  [0:4];
  logic [31:0] e_a   [0:4];
  logic        e_we  [0:4];
  int          seen, rc [0:7];
  logic [31:0] rd [0:7];

  initial begin
    for (int i = 0; i < 256; i++) begin
      s_mem[i] = 8'h00;
      n_mem[i] = 8'h00;
    end
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, s_req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, s_resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, s_resp_err}, 32'd0);
    check("rst_resp_rdata", s_resp_rdata, 32'd0);
    check("rst_mem_we", {31'd0, s_mem_we}, 32'd0);
    check("rst_width", {30'd0, s_mem_width_src}, 32'd0);
    check("rst_mem_addr", s_mem_addr, 32'd0);
    check("rst_mem_wdata", s_mem_wdata, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: aligned word store and load
    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check("sw_cyc", r_cyc, 32'd2);
    check("sw_nbeats", nb, 32'd1);
    check("sw_width", {30'd0, b_ws[0]}, 32'd0);
    check("sw_addr", b_addr[0], 32'h10);
    check("sw_wdata", b_wd[0], 32'hDEADBEEF);
    check("sw_we_cycles", n_we, 32'd1);
    check("sw_err", {31'd0, r_err}, 32'd0);
    check("sw_rdata", r_rdata, 32'd0);
    check("sw_ready_busy", n_ready, 32'd0);
    run_req(1'b0, 3'b010, 32'h10, 32'd0);
    check("lw_cyc", r_cyc, 32'd2);
    check("lw_rdata", r_rdata, 32'hDEADBEEF);
    check("lw_we_cycles", n_we, 32'd0);
    check("lw_ns_cyc", ns_cyc, 32'd2);
    check("lw_ns_err", {31'd0, ns_err}, 32'd0);

    // 2: byte store and sign/zero-extended loads
    run_req(1'b1, 3'b000, 32'h21, 32'h80);
    check("sb_cyc", r_cyc, 32'd2);
    check("sb_width", {30'd0, b_ws[0]}, 32'd1);
    run_req(1'b0, 3'b000, 32'h21, 32'd0);
    check("lb_rdata", r_rdata, 32'hFFFFFF80);
    run_req(1'b0, 3'b100, 32'h21, 32'd0);
    check("lbu_rdata", r_rdata, 32'h00000080);
    run_req(1'b0, 3'b001, 32'h20, 32'd0);
    check("lh_rdata", r_rdata, 32'hFFFF8000);
    check("lh_width", {30'd0, b_ws[0]}, 32'd2);

    // 3: misaligned word split into byte beats; non-split instance rejects it
    exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
    run_req(1'b1, 3'b010, 32'h05, 32'h11223344);
    check("msw_cyc", r_cyc, 32'd5);
    check("msw_nbeats", nb, 32'd4);
    check("msw_we_cycles", n_we, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("msw_addr%0d", i), b_addr[i], 32'h05 + i);
      check($sformatf("msw_wd%0d", i), b_wd[i] & 32'hFF, {24'd0, exp_b[i]});
      check($sformatf("msw_ws%0d", i), {30'd0, b_ws[i]}, 32'd1);
    end
    check("msw_ns_cyc", ns_cyc, 32'd1);
    check("msw_ns_err", {31'd0, ns_err}, 32'd1);
    check("msw_ns_we", ns_we, 32'd0);
    run_req(1'b0, 3'b010, 32'h05, 32'd0);
    check("mlw_cyc", r_cyc, 32'd5);
    check("mlw_rdata", r_rdata, 32'h11223344);
    check("mlw_ns_err", {31'd0, ns_err}, 32'd1);

    // 4: rejected requests
    e_we[0] = 1'b0; e_f3[0] = 3'b010; e_a[0] = 32'h000000FE;
    e_we[1] = 1'b0; e_f3[1] = 3'b001; e_a[1] = 32'h000000FF;
    e_we[2] = 1'b0; e_f3[2] = 3'b011; e_a[2] = 32'h00000010;
    e_we[3] = 1'b1; e_f3[3] = 3'b100; e_a[3] = 32'h00000010;
    e_we[4] = 1'b0; e_f3[4] = 3'b010; e_a[4] = 32'hFFFFFFFE;
    for (int i = 0; i < 5; i++) begin
      run_req(e_we[i], e_f3[i], e_a[i], 32'hFFFFFFFF);
      check($sformatf("err%0d_cyc", i), r_cyc, 32'd1);
      check($sformatf("err%0d_flag", i), {31'd0, r_err}, 32'd1);
      check($sformatf("err%0d_rdata", i), r_rdata, 32'd0);
      check($sformatf("err%0d_we", i), n_we, 32'd0);
    end
    run_req(1'b0, 3'b000, 32'hFF, 32'd0);
    check("lb_top_cyc", r_cyc, 32'd2);
    check("lb_top_err", {31'd0, r_err}, 32'd0);

    // 5: reset in the middle of a split store
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h05;
    req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_beat2_we", {31'd0, s_mem_we}, 32'd1);
    check("abort_beat2_addr", s_mem_addr, 32'h07);
    reset = 1'b0;
    #1;
    check("abort_we_drop", {31'd0, s_mem_we}, 32'd0);
    check("abort_addr_zero", s_mem_addr, 32'd0);
    check("abort_ready", {31'd0, s_req_ready}, 32'd1);
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (s_resp_valid) seen++;
    end
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (s_resp_valid) seen++;
    end
    check("abort_no_resp", seen, 32'd0);
    check("abort_ready_after", {31'd0, s_req_ready}, 32'd1);
    run_req(1'b0, 3'b000, 32'h07, 32'd0);
    check("abort_lb07", r_rdata, 32'h00000022);
    run_req(1'b0, 3'b000, 32'h06, 32'd0);
    check("abort_lb06", r_rdata, 32'hFFFFFFCC);

    // 6: req_valid held high across two back-to-back requests
    seen = 0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    req_wdata = 32'd0;
    @(posedge clk); #1;
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) begin
        req_funct3 = 3'b100; req_addr = 32'h21;
      end
      if (c == 4) req_valid = 1'b0;
      if (c == 1 || c == 2 || c == 4 || c == 5)
        check($sformatf("b2b_ready_c%0d", c), {31'd0, s_req_ready}, 32'd0);
      if (s_resp_valid && seen < 8) begin
        rc[seen] = c; rd[seen] = s_resp_rdata; seen++;
      end
      @(posedge clk); #1;
    end
    check("b2b_count", seen, 32'd2);
    if (seen >= 2) begin
      check("b2b_cyc0", rc[0], 32'd2);
      check("b2b_data0", rd[0], 32'hDEADBEEF);
      check("b2b_cyc1", rc[1], 32'd5);
      check("b2b_data1", rd[1], 32'h00000080);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
